// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: NOP word, PC defaults, fetch FSM
// encodings and the IF/ID register payload.
package mips_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD       = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0000_0800;
  localparam logic [XLEN-1:0] PC_STEP        = 32'd4;

  // Fetch FSM encodings
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  // Redirect targets are word aligned by dropping the byte offset
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: pipeline control/redirect inputs, instruction
// memory port and IF/ID outputs.
//   master : the fetch stage (drives pc, imem_addr, IF/ID, halted, count)
//   slave  : the surrounding pipeline / memory / bench
interface if_stage_if #(
  parameter int unsigned IMEM_ADDR_W = 10
);

  logic                   stall;
  logic                   flush;
  logic                   br_take;
  logic [31:0]            br_target;
  logic                   jmp_take;
  logic [31:0]            jmp_target;
  logic                   eret_take;
  logic [31:0]            epc;
  logic                   int_take;
  logic                   halt_req;
  logic                   resume;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_data;
  logic [31:0]            pc;
  logic [31:0]            if_id_ir;
  logic [31:0]            if_id_pc;
  logic [31:0]            if_id_pc4;
  logic                   if_id_valid;
  logic                   halted;
  logic [31:0]            fetch_count;

  modport master (
    input  stall, flush, br_take, br_target, jmp_take, jmp_target,
           eret_take, epc, int_take, halt_req, resume, imem_data,
    output imem_addr, pc, if_id_ir, if_id_pc, if_id_pc4, if_id_valid,
           halted, fetch_count
  );

  modport slave (
    output stall, flush, br_take, br_target, jmp_take, jmp_target,
           eret_take, epc, int_take, halt_req, resume, imem_data,
    input  imem_addr, pc, if_id_ir, if_id_pc, if_id_pc4, if_id_valid,
           halted, fetch_count
  );

endinterface

// File: rtl/if_stage_npc_sel.sv
// Next-PC priority mux: int_take > eret_take > br_take > jmp_take > stall
// (hold) > pc+4. Redirect targets are word aligned and override stall.
//   pc          current fetch PC
//   *_take/*    redirect requests and their targets
//   stall       hold PC when no redirect
//   next_pc_c   selected next PC
//   redirect_c  any redirect selected
module if_stage_npc_sel
  import mips_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] pc,
  input  logic        int_take,
  input  logic        eret_take,
  input  logic [31:0] epc,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        jmp_take,
  input  logic [31:0] jmp_target,
  input  logic        stall,
  output logic [31:0] next_pc_c,
  output logic        redirect_c
);

  always_comb begin
    next_pc_c  = pc + PC_STEP;
    redirect_c = 1'b0;
    if (int_take) begin
      next_pc_c  = align_word(EXC_VECTOR);
      redirect_c = 1'b1;
    end else if (eret_take) begin
      next_pc_c  = align_word(epc);
      redirect_c = 1'b1;
    end else if (br_take) begin
      next_pc_c  = align_word(br_target);
      redirect_c = 1'b1;
    end else if (jmp_take) begin
      next_pc_c  = align_word(jmp_target);
      redirect_c = 1'b1;
    end else if (stall) begin
      next_pc_c  = pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, selects next PC, addresses
// instruction memory and registers the fetched word into IF/ID. Includes a
// RUN/HALT FSM for the syscall-halt path and a valid-fetch counter.
//   clk, rst  single clock, synchronous active-high reset
//   bus       if_stage_if master: controls/redirects in, imem port,
//             pc, IF/ID register, halted, fetch_count out
module if_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int unsigned IMEM_ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.master   bus
);

  logic [31:0] pc_q;
  if_id_t      if_id_q;
  logic [0:0]  state_q;
  logic [0:0]  state_nxt;
  logic        halted_q;
  logic [31:0] count_q;

  logic        run_c;
  logic [31:0] pc_nxt_c;
  logic        redirect_c;
  logic        bubble_c;
  logic        load_c;

  assign run_c = (state_q == ST_RUN);

  // In HALT only int_take may move the PC; everything else is masked and
  // the PC is held by forcing the stall path.
  if_stage_npc_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_sel (
    .pc         (pc_q),
    .int_take   (bus.int_take),
    .eret_take  (bus.eret_take & run_c),
    .epc        (bus.epc),
    .br_take    (bus.br_take & run_c),
    .br_target  (bus.br_target),
    .jmp_take   (bus.jmp_take & run_c),
    .jmp_target (bus.jmp_target),
    .stall      (bus.stall | ~run_c),
    .next_pc_c  (pc_nxt_c),
    .redirect_c (redirect_c)
  );

  // FSM next state and IF/ID load/bubble decision
  always_comb begin
    state_nxt = state_q;
    bubble_c  = 1'b0;
    load_c    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.halt_req) begin
          state_nxt = ST_HALT;
        end
        // flush bubbles IF/ID even while stalled
        if (redirect_c || bus.halt_req || bus.flush) begin
          bubble_c = 1'b1;
        end else if (!bus.stall) begin
          load_c = 1'b1;
        end
      end
      ST_HALT: begin
        bubble_c = 1'b1;
        if (bus.int_take || bus.resume) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        bubble_c  = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
      pc_q     <= RESET_PC;
      if_id_q  <= '{ir: NOP_WORD, pc: 32'd0, pc4: 32'd0, valid: 1'b0};
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_nxt;
      halted_q <= (state_nxt == ST_HALT);
      pc_q     <= pc_nxt_c;
      if (bubble_c) begin
        // bubble keeps the previous pc/pc4 fields
        if_id_q.ir    <= NOP_WORD;
        if_id_q.valid <= 1'b0;
      end else if (load_c) begin
        if_id_q <= '{ir: bus.imem_data, pc: pc_q, pc4: pc_q + PC_STEP,
                     valid: 1'b1};
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.imem_addr   = pc_q[IMEM_ADDR_W+1:2];
  assign bus.if_id_ir    = if_id_q.ir;
  assign bus.if_id_pc    = if_id_q.pc;
  assign bus.if_id_pc4   = if_id_q.pc4;
  assign bus.if_id_valid = if_id_q.valid;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] EXC = 32'h0000_0800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_if #(.IMEM_ADDR_W(10)) bus ();

  if_stage #(
    .RESET_PC    (32'h0000_0000),
    .EXC_VECTOR  (EXC),
    .IMEM_ADDR_W (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: word at byte address a reads as a | 0xA000_0000
  assign bus.imem_data = 32'hA000_0000 | {20'h0, bus.imem_addr, 2'b00};

  int n_checks = 0;
  int n_err    = 0;

  // Reference state
  logic [31:0] m_pc, m_ir, m_ifpc, m_ifpc4, m_cnt;
  logic        m_valid, m_halted;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | (a & 32'h0000_0FFC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the fetch-stage rules for the edge about to happen
  task automatic model_edge();
    logic        redir;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_ir = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'h0;
    end else if (m_halted) begin
      m_ir = 32'h0; m_valid = 1'b0;
      if (bus.int_take) begin
        m_pc = EXC; m_halted = 1'b0;
      end else if (bus.resume) begin
        m_halted = 1'b0;
      end
    end else begin
      redir = bus.int_take | bus.eret_take | bus.br_take | bus.jmp_take;
      tgt = bus.int_take  ? EXC :
            bus.eret_take ? bus.epc :
            bus.br_take   ? bus.br_target : bus.jmp_target;
      tgt = tgt & 32'hFFFF_FFFC;
      if (redir || bus.halt_req || bus.flush) begin
        m_ir = 32'h0; m_valid = 1'b0;
      end else if (!bus.stall) begin
        m_ir = mem_word(m_pc); m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
        m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end
      if (redir)           m_pc = tgt;
      else if (!bus.stall) m_pc = m_pc + 32'd4;
      if (bus.halt_req) m_halted = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("pc", bus.pc, m_pc);
    chk("imem_addr", 32'(bus.imem_addr), (m_pc >> 2) & 32'h3FF);
    chk("if_id_ir", bus.if_id_ir, m_ir);
    chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
    if (m_valid) begin
      chk("if_id_pc", bus.if_id_pc, m_ifpc);
      chk("if_id_pc4", bus.if_id_pc4, m_ifpc4);
    end
    chk("halted", 32'(bus.halted), 32'(m_halted));
    chk("fetch_count", bus.fetch_count, m_cnt);
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.br_take = 1'b0; bus.br_target = 32'h0;
    bus.jmp_take = 1'b0; bus.jmp_target = 32'h0;
    bus.eret_take = 1'b0; bus.epc = 32'h0;
    bus.int_take = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst_ir", bus.if_id_ir, 32'h0);
    rst = 1'b0;

    // free run
    step(); chk("run1_pc", bus.if_id_pc, 32'h0);
    step(); chk("run2_pc", bus.if_id_pc, 32'h4);
    step(); chk("run3_pc", bus.if_id_pc, 32'h8);
    chk("run3_cnt", bus.fetch_count, 32'd3);

    // stall two cycles then release
    bus.stall = 1'b1;
    step(); step();
    chk("stall_cnt", bus.fetch_count, 32'd3);
    bus.stall = 1'b0;
    step(); chk("unstall_pc", bus.if_id_pc, 32'hC);

    // branch overrides stall, target realigned
    bus.br_take = 1'b1; bus.br_target = 32'h43; bus.stall = 1'b1;
    step(); chk("br_pc", bus.pc, 32'h40);
    chk("br_valid", 32'(bus.if_id_valid), 32'h0);
    idle();
    step(); chk("br_ifpc", bus.if_id_pc, 32'h40);

    // interrupt wins over eret and branch
    bus.int_take = 1'b1; bus.eret_take = 1'b1; bus.epc = 32'h100;
    bus.br_take = 1'b1; bus.br_target = 32'h200;
    step(); chk("int_pc", bus.pc, EXC);
    idle();
    bus.eret_take = 1'b1; bus.epc = 32'h102; bus.jmp_take = 1'b1; bus.jmp_target = 32'h300;
    step(); chk("eret_pc", bus.pc, 32'h100);
    idle();

    // flush without redirect
    step();
    bus.flush = 1'b1;
    step();
    idle();

    // halt at 0x10 (stalled so the PC holds), then resume
    bus.jmp_take = 1'b1; bus.jmp_target = 32'h10;
    step(); idle();
    bus.halt_req = 1'b1; bus.stall = 1'b1;
    step(); idle();
    chk("halt_h", 32'(bus.halted), 32'h1);
    bus.br_take = 1'b1; bus.br_target = 32'h500; bus.flush = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("halt_pc", bus.pc, 32'h10);
    idle();
    bus.resume = 1'b1;
    step(); idle();
    chk("resume_h", 32'(bus.halted), 32'h0);
    step(); chk("resume_ifpc", bus.if_id_pc, 32'h10);

    // halt again, int_take with resume leaves to the exception vector
    bus.halt_req = 1'b1;
    step(); idle();
    step();
    bus.int_take = 1'b1; bus.resume = 1'b1;
    step(); idle();
    chk("halt_int_pc", bus.pc, EXC);
    chk("halt_int_h", 32'(bus.halted), 32'h0);

    // PC wrap
    bus.jmp_take = 1'b1; bus.jmp_target = 32'hFFFF_FFFE;
    step(); idle();
    step(); chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_pc4", bus.if_id_pc4, 32'h0);

    // reset mid-stream
    step();
    rst = 1'b1;
    step(); chk("rst2_cnt", bus.fetch_count, 32'h0);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(99) == 0);
      bus.int_take  = ($urandom_range(19) == 0);
      bus.eret_take = ($urandom_range(11) == 0);
      bus.br_take   = ($urandom_range(7) == 0);
      bus.jmp_take  = ($urandom_range(9) == 0);
      bus.stall     = ($urandom_range(3) == 0);
      bus.flush     = ($urandom_range(7) == 0);
      bus.halt_req  = ($urandom_range(29) == 0);
      bus.resume    = ($urandom_range(3) == 0);
      bus.epc        = $urandom();
      bus.br_target  = $urandom();
      bus.jmp_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
